wb_intercon_n: RTL and testbench



---
 rtl/wb_intercon_n.sv | 195 +++++++++++++++++++
 tb/tb_wb_intercon_n.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon_n.sv
// Single-master Wishbone interconnect: address decode to N slaves, one outstanding access.
// Optional slave-response timeout enabled by defining WB_INTERCON_TIMEOUT_EN.
module wb_intercon_n #(
    parameter int                        DATA_WIDTH     = 16,
    parameter int                        NUM_SLAVES     = 6,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASKS    = '0,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_ADDRS    = '0,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [31:0]                      wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
    input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
    input  logic                             wbm_we_i,
    input  logic                             wbm_cyc_i,
    input  logic                             wbm_stb_i,
    output logic [DATA_WIDTH-1:0]            wbm_dat_o,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic [31:0]                      wbs_adr_o,
    output logic [DATA_WIDTH-1:0]            wbs_dat_o,
    output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
    output logic                             wbs_we_o,
    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    input  logic [DATA_WIDTH*NUM_SLAVES-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    output logic                             fault_o,
    output logic [31:0]                      fault_adr_o
);

    localparam int SW = DATA_WIDTH / 8;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
        $error("wb_intercon_n: NUM_SLAVES out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("wb_intercon_n: TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic                    we_q, we_d;
    logic [NUM_SLAVES-1:0]   oh_q, oh_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    fault_q, fault_d;
    logic [31:0]             fault_adr_q, fault_adr_d;

    logic [NUM_SLAVES-1:0]   hit_oh;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    acked;
    logic                    tmo;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_oh = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((wbm_adr_i & SLAVE_MASKS[32*k +: 32]) ==
                (SLAVE_ADDRS[32*k +: 32] & SLAVE_MASKS[32*k +: 32])) begin
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (oh_q[k]) begin
                sel_dat = sel_dat | wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign acked = |(wbs_ack_i & oh_q);

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo = (cnt_q == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        oh_d        = oh_q;
        rdat_d      = rdat_q;
        fault_d     = fault_q;
        fault_adr_d = fault_adr_q;
        unique case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_d = wbm_adr_i;
                    dat_d = wbm_dat_i;
                    sel_d = wbm_sel_i;
                    we_d  = wbm_we_i;
                    oh_d  = hit_oh;
                    if (|hit_oh) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = ERR;
                        if (!fault_q) begin
                            fault_d     = 1'b1;
                            fault_adr_d = wbm_adr_i;
                        end
                    end
                end
            end
            ACCESS: begin
                // Abort wins over a coincident ack: the master has gone away.
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (acked) begin
                    rdat_d  = sel_dat;
                    state_d = RESP;
                end else if (tmo) begin
                    state_d = ERR;
                    if (!fault_q) begin
                        fault_d     = 1'b1;
                        fault_adr_d = adr_q;
                    end
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            oh_q        <= '0;
            rdat_q      <= '0;
            fault_q     <= 1'b0;
            fault_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            oh_q        <= oh_d;
            rdat_q      <= rdat_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
        end
    end

    assign wbs_adr_o   = adr_q;
    assign wbs_dat_o   = dat_q;
    assign wbs_sel_o   = sel_q;
    assign wbs_we_o    = we_q;
    assign wbs_cyc_o   = (state_q == ACCESS) ? oh_q : '0;
    assign wbs_stb_o   = (state_q == ACCESS) ? oh_q : '0;
    assign wbm_dat_o   = rdat_q;
    assign wbm_ack_o   = (state_q == RESP);
    assign wbm_err_o   = (state_q == ERR);
    assign fault_o     = fault_q;
    assign fault_adr_o = fault_adr_q;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Directed self-checking bench for wb_intercon_n (6 slaves, timeout 8).
// Covers decode, priority, miss/fault, timeout or hang, abort and reset.
module tb_wb_intercon_n;

    localparam int DW = 16;
    localparam int NS = 6;
    localparam int TMO = 8;
    localparam logic [32*NS-1:0] MASKS = {
        32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_F000,
        32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000};
    localparam logic [32*NS-1:0] ADDRS = {
        32'h6000_0000, 32'hF000_0000, 32'h1000_0000,
        32'h5000_0000, 32'hF000_0000, 32'h3000_0000};

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     wbm_adr;
    logic [DW-1:0]   wbm_dat;
    logic [DW/8-1:0] wbm_sel;
    logic            wbm_we, wbm_cyc, wbm_stb;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_ack_o, wbm_err_o;
    logic [31:0]     wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [DW/8-1:0] wbs_sel_o;
    logic            wbs_we_o;
    logic [NS-1:0]   wbs_cyc_o, wbs_stb_o;
    logic [DW*NS-1:0] wbs_dat;
    logic [NS-1:0]   wbs_ack;
    logic            fault_o;
    logic [31:0]     fault_adr_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_intercon_n #(
        .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SLAVE_MASKS(MASKS), .SLAVE_ADDRS(ADDRS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_i(wbm_sel),
        .wbm_we_i(wbm_we), .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat), .wbs_ack_i(wbs_ack),
        .fault_o(fault_o), .fault_adr_o(fault_adr_o)
    );

    task automatic request(input logic [31:0] a, input logic we,
                           input logic [DW-1:0] d);
        wbm_adr = a;
        wbm_we  = we;
        wbm_dat = d;
        wbm_sel = '1;
        wbm_cyc = 1'b1;
        wbm_stb = 1'b1;
    endtask

    task automatic release_req();
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        release_req();
        wbm_adr = '0; wbm_dat = '0; wbm_sel = '0; wbm_we = 1'b0;
        wbs_dat = '0; wbs_ack = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wbm_ack_o, wbm_err_o, wbs_stb_o, wbs_cyc_o, fault_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl: got ack=%b err=%b stb=%b cyc=%b flt=%b required all 0",
                     wbm_ack_o, wbm_err_o, wbs_stb_o, wbs_cyc_o, fault_o);
        end
        n_checks++;
        if ({wbm_dat_o, fault_adr_o, wbs_adr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got dat=%h fadr=%h adr=%h required 0",
                     wbm_dat_o, fault_adr_o, wbs_adr_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        request(32'h1000_0010, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== 6'b001000 || wbs_cyc_o !== 6'b001000) begin
            n_fail++;
            $display("FAIL read_strobe: got stb=%b cyc=%b required 001000",
                     wbs_stb_o, wbs_cyc_o);
        end
        n_checks++;
        if (wbs_adr_o !== 32'h1000_0010 || wbs_we_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_bus: got adr=%h we=%b ack=%b required 10000010 0 0",
                     wbs_adr_o, wbs_we_o, wbm_ack_o);
        end
        wbs_dat[2*DW +: DW] = 16'h5555;
        wbs_ack = 6'b000100;
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== 6'b001000 || wbm_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ignore_other_ack: got stb=%b ack=%b required 001000 0",
                     wbs_stb_o, wbm_ack_o);
        end
        wbs_dat[3*DW +: DW] = 16'hBEEF;
        wbs_ack = 6'b001000;
        @(negedge clk);
        wbs_ack = '0;
        n_checks++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 16'hBEEF || wbs_stb_o !== '0) begin
            n_fail++;
            $display("FAIL read_resp: got ack=%b dat=%h stb=%b required 1 beef 000000",
                     wbm_ack_o, wbm_dat_o, wbs_stb_o);
        end
        release_req();
        @(negedge clk);
        n_checks++;
        if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack_len: got ack=%b err=%b required 0 0",
                     wbm_ack_o, wbm_err_o);
        end
    endtask

    task automatic test_miss();
        request(32'h2000_0000, 1'b1, 16'h1111);
        @(negedge clk);
        n_checks++;
        if (wbm_err_o !== 1'b1 || wbs_stb_o !== '0 || wbm_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_err: got err=%b stb=%b ack=%b required 1 000000 0",
                     wbm_err_o, wbs_stb_o, wbm_ack_o);
        end
        n_checks++;
        if (fault_o !== 1'b1 || fault_adr_o !== 32'h2000_0000 || wbm_dat_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL miss_fault: got flt=%b fadr=%h dat=%h required 1 20000000 beef",
                     fault_o, fault_adr_o, wbm_dat_o);
        end
        release_req();
        @(negedge clk);
        n_checks++;
        if (wbm_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_err_len: got err=%b required 0", wbm_err_o);
        end
        request(32'h2000_0004, 1'b0, 16'h0000);
        @(negedge clk);
        release_req();
        n_checks++;
        if (wbm_err_o !== 1'b1 || fault_adr_o !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL miss_sticky: got err=%b fadr=%h required 1 20000000",
                     wbm_err_o, fault_adr_o);
        end
        @(negedge clk);
    endtask

    task automatic test_overlap();
        request(32'hF000_0000, 1'b1, 16'hA5A5);
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== 6'b000010 || wbs_dat_o !== 16'hA5A5 || wbs_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_sel: got stb=%b dat=%h we=%b required 000010 a5a5 1",
                     wbs_stb_o, wbs_dat_o, wbs_we_o);
        end
        wbs_dat[1*DW +: DW] = 16'h1234;
        wbs_ack = 6'b000010;
        @(negedge clk);
        wbs_ack = '0;
        release_req();
        n_checks++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL overlap_resp: got ack=%b dat=%h required 1 1234",
                     wbm_ack_o, wbm_dat_o);
        end
        @(negedge clk);
    endtask

`ifdef WB_INTERCON_TIMEOUT_EN
    task automatic test_timeout();
        int  stb_cycles = 0;
        bit  got_err = 1'b0;
        request(32'h1000_0020, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !got_err; i++) begin
            @(negedge clk);
            if (wbm_err_o) got_err = 1'b1;
            else if (wbs_stb_o == 6'b001000) stb_cycles++;
        end
        release_req();
        n_checks++;
        if (!got_err || stb_cycles !== TMO) begin
            n_fail++;
            $display("FAIL timeout_len: got err_seen=%0d access_cycles=%0d required 1 %0d",
                     got_err, stb_cycles, TMO);
        end
        n_checks++;
        if (wbs_stb_o !== '0 || fault_adr_o !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL timeout_state: got stb=%b fadr=%h required 000000 20000000",
                     wbs_stb_o, fault_adr_o);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        int errs = 0;
        request(32'h1000_0020, 1'b0, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wbm_err_o || wbm_ack_o) errs++;
        end
        n_checks++;
        if (wbs_stb_o !== 6'b001000 || errs !== 0) begin
            n_fail++;
            $display("FAIL no_timeout_hold: got stb=%b responses=%0d required 001000 0",
                     wbs_stb_o, errs);
        end
        release_req();
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== '0 || wbm_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_abort: got stb=%b err=%b required 000000 0",
                     wbs_stb_o, wbm_err_o);
        end
    endtask
`endif

    task automatic test_abort();
        request(32'h1000_0030, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== 6'b001000) begin
            n_fail++;
            $display("FAIL abort_pre: got stb=%b required 001000", wbs_stb_o);
        end
        release_req();
        @(negedge clk);
        n_checks++;
        if (wbs_stb_o !== '0 || wbs_cyc_o !== '0) begin
            n_fail++;
            $display("FAIL abort_drop: got stb=%b cyc=%b required 0", wbs_stb_o, wbs_cyc_o);
        end
        wbs_dat[3*DW +: DW] = 16'h7777;
        wbs_ack = 6'b001000;
        @(negedge clk);
        wbs_ack = '0;
        n_checks++;
        if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 || wbm_dat_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL abort_late_ack: got ack=%b err=%b dat=%h required 0 0 1234",
                     wbm_ack_o, wbm_err_o, wbm_dat_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        request(32'h1000_0040, 1'b0, 16'h0000);
        @(negedge clk);
        #1 rst = 1'b1;
        release_req();
        #1;
        n_checks++;
        if ({wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, fault_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got stb=%b cyc=%b ack=%b err=%b flt=%b required 0",
                     wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, fault_o);
        end
        n_checks++;
        if ({wbm_dat_o, fault_adr_o, wbs_adr_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got dat=%h fadr=%h adr=%h required 0",
                     wbm_dat_o, fault_adr_o, wbs_adr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        wbs_ack = 6'b001000;
        @(negedge clk);
        wbs_ack = '0;
        n_checks++;
        if (wbm_ack_o !== 1'b0 || wbs_stb_o !== '0) begin
            n_fail++;
            $display("FAIL rst_stray_ack: got ack=%b stb=%b required 0 0",
                     wbm_ack_o, wbs_stb_o);
        end
        request(32'h1000_0050, 1'b0, 16'h0000);
        @(negedge clk);
        wbs_dat[3*DW +: DW] = 16'hC0DE;
        wbs_ack = 6'b001000;
        @(negedge clk);
        wbs_ack = '0;
        release_req();
        n_checks++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL rst_post_read: got ack=%b dat=%h required 1 c0de",
                     wbm_ack_o, wbm_dat_o);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_miss();
        test_overlap();
        test_timeout();
        test_abort();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
